// File: rtl/count_seq_checker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// count_seq_checker_pkg : shared state encoding and default lock/loss depths
// Revision 1.0
// ---------------------------------------------------------------------------
package count_seq_checker_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int c_DEF_LOCK_COUNT = 4;
  localparam int c_DEF_LOSS_COUNT = 3;

endpackage
`default_nettype wire

// File: rtl/count_seq_checker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// count_seq_checker_if : sample stream in, link-integrity status out
// Revision 1.0
// ---------------------------------------------------------------------------
interface count_seq_checker_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_WIDTH = 8
);
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 clear;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_WIDTH-1:0] err_count;
  logic [WIDTH-1:0]     expected;

  modport master (
    output in_valid, in_data, clear,
    input  locked, err_pulse, err_count, expected
  );

  modport slave (
    input  in_valid, in_data, clear,
    output locked, err_pulse, err_count, expected
  );
endinterface
`default_nettype wire

// File: rtl/count_seq_checker_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : up-counter that holds at all-ones; clear wins over increment
// Revision 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/count_seq_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// count_seq_checker : locks onto an incrementing word stream and counts breaks
// Revision 1.0
// ---------------------------------------------------------------------------
module count_seq_checker
  import count_seq_checker_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = c_DEF_LOCK_COUNT,
  parameter int LOSS_COUNT = c_DEF_LOSS_COUNT,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  count_seq_checker_if.slave  bus
);

  localparam logic [3:0] c_LOCK = 4'(LOCK_COUNT);
  localparam logic [3:0] c_LOSS = 4'(LOSS_COUNT);

  state_t           r_state;
  logic [3:0]       r_run;
  logic [3:0]       r_miss;
  logic [WIDTH-1:0] r_expected;
  logic             r_pulse;
  logic             r_locked;

  state_t           w_state_nxt;
  logic [3:0]       w_run_nxt;
  logic [3:0]       w_miss_nxt;
  logic [WIDTH-1:0] w_exp_nxt;
  logic             w_pulse_nxt;
  logic             w_err_inc;
  logic             w_match;
  logic [3:0]       w_run_inc;
  logic [3:0]       w_miss_inc;

  assign w_match    = (bus.in_data == r_expected);
  assign w_run_inc  = r_run + 4'd1;
  assign w_miss_inc = r_miss + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= SEARCH;
      r_run      <= 4'd0;
      r_miss     <= 4'd0;
      r_expected <= '0;
      r_pulse    <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= w_run_nxt;
      r_miss     <= w_miss_nxt;
      r_expected <= w_exp_nxt;
      r_pulse    <= w_pulse_nxt;
      r_locked   <= (w_state_nxt == LOCKED);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_miss_nxt  = r_miss;
    w_exp_nxt   = r_expected;
    w_pulse_nxt = 1'b0;
    w_err_inc   = 1'b0;
    if (bus.in_valid) begin
      // Every accepted word re-seeds the prediction, whatever the state
      w_exp_nxt = bus.in_data + WIDTH'(1);
      case (r_state)
        SEARCH: begin
          w_run_nxt   = 4'd1;
          w_state_nxt = LOCKING;
        end
        LOCKING: begin
          if (w_match) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == c_LOCK) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = 4'd0;
            end
          end else begin
            w_run_nxt = 4'd1;
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_miss_nxt = 4'd0;
          end else begin
            w_pulse_nxt = 1'b1;
            w_err_inc   = 1'b1;
            w_miss_nxt  = w_miss_inc;
            if (w_miss_inc == c_LOSS) begin
              w_state_nxt = SEARCH;
            end
          end
        end
        default: begin
          w_state_nxt = SEARCH;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (ERR_WIDTH)
  ) u_err_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_err_inc),
    .i_clr   (bus.clear),
    .o_count (bus.err_count)
  );

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_pulse;
  assign bus.expected  = r_expected;

endmodule
`default_nettype wire
